// File: rtl/ctl_paddles.sv
// ---------------------------------------------------------------------------
// ctl_paddles
// Drives N_PLY independent paddle positions from raw up/down buttons. Each
// channel synchronises its buttons, moves only on the frame tick, speeds up
// while a direction is held and saturates at the top/bottom limits.
//
// Ports
//   clk       in   system clock, all state on posedge
//   rst       in   asynchronous active-high reset
//   tick      in   one-clk frame strobe; positions move only on tick
//   btn_up    in   [N_PLY]        raw up buttons (asynchronous)
//   btn_down  in   [N_PLY]        raw down buttons (asynchronous)
//   pos       out  [N_PLY*POS_W]  packed positions, channel i at [i*POS_W +: POS_W]
//   at_top    out  [N_PLY]        position equals POS_MIN
//   at_bot    out  [N_PLY]        position equals POS_MAX
//   moving    out  [N_PLY]        channel is in its RUN state
// ---------------------------------------------------------------------------
module ctl_paddles #(
   parameter int N_PLY        = 2,
   parameter int POS_W        = 10,
   parameter int POS_MIN      = 5,
   parameter int POS_MAX      = 590,
   parameter int POS_INIT     = 63,
   parameter int SPEED_MIN    = 1,
   parameter int SPEED_MAX    = 4,
   parameter int ACCEL_FRAMES = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     tick,
   input  logic [N_PLY-1:0]         btn_up,
   input  logic [N_PLY-1:0]         btn_down,
   output logic [N_PLY*POS_W-1:0]   pos,
   output logic [N_PLY-1:0]         at_top,
   output logic [N_PLY-1:0]         at_bot,
   output logic [N_PLY-1:0]         moving
);

   localparam int SPD_W = $clog2(SPEED_MAX + 1);
   localparam int HC_W  = (ACCEL_FRAMES > 1) ? $clog2(ACCEL_FRAMES) : 1;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   localparam logic [1:0] DIR_NONE = 2'b00;
   localparam logic [1:0] DIR_DOWN = 2'b01;
   localparam logic [1:0] DIR_UP   = 2'b10;

   // Limits widened by one bit so step sums/compares cannot wrap.
   localparam logic [POS_W:0]    MIN_X    = (POS_W+1)'(POS_MIN);
   localparam logic [POS_W:0]    MAX_X    = (POS_W+1)'(POS_MAX);
   localparam logic [POS_W-1:0]  MIN_P    = POS_W'(POS_MIN);
   localparam logic [POS_W-1:0]  MAX_P    = POS_W'(POS_MAX);
   localparam logic [POS_W-1:0]  INIT_P   = POS_W'(POS_INIT);
   localparam logic [SPD_W-1:0]  SPD_LO   = SPD_W'(SPEED_MIN);
   localparam logic [SPD_W-1:0]  SPD_HI   = SPD_W'(SPEED_MAX);
   localparam logic [HC_W-1:0]   HC_LAST  = HC_W'(ACCEL_FRAMES - 1);

   // Parameter sanity, evaluated at elaboration.
   if (!((POS_MIN <= POS_INIT) && (POS_INIT <= POS_MAX) && (POS_MAX < (2 ** POS_W)))) begin : g_bad_pos
      $error("ctl_paddles: need POS_MIN <= POS_INIT <= POS_MAX < 2**POS_W");
   end
   if (!((SPEED_MIN >= 1) && (SPEED_MIN <= SPEED_MAX))) begin : g_bad_spd
      $error("ctl_paddles: need 1 <= SPEED_MIN <= SPEED_MAX");
   end
   if (!(SPEED_MAX <= (POS_MAX - POS_MIN))) begin : g_bad_range
      $error("ctl_paddles: need SPEED_MAX <= POS_MAX - POS_MIN");
   end
   if (!(ACCEL_FRAMES >= 1)) begin : g_bad_accel
      $error("ctl_paddles: need ACCEL_FRAMES >= 1");
   end

   for (genvar g = 0; g < N_PLY; g++) begin : g_ch
      logic [1:0]        up_sync_q;   // [0] first stage, [1] usable
      logic [1:0]        dn_sync_q;
      logic [0:0]        state_q,    state_d;
      logic [SPD_W-1:0]  spd_q,      spd_d;
      logic [HC_W-1:0]   hcnt_q,     hcnt_d;
      logic [1:0]        last_dir_q, last_dir_d;
      logic [POS_W-1:0]  pos_q,      pos_d;
      logic [1:0]        dir_s;
      logic              restart_s;
      logic              clamp_s;
      logic [SPD_W-1:0]  step_s;
      logic [POS_W:0]    pos_x_s;
      logic [POS_W:0]    step_x_s;
      logic [POS_W:0]    sum_x_s;
      logic [POS_W-1:0]  diff_s;
      logic [POS_W-1:0]  next_pos_s;

      // Two-flop synchronisers for the raw buttons.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            up_sync_q <= 2'b00;
            dn_sync_q <= 2'b00;
         end else begin
            up_sync_q <= {up_sync_q[0], btn_up[g]};
            dn_sync_q <= {dn_sync_q[0], btn_down[g]};
         end
      end

      // Direction decode: exactly one button pressed moves, otherwise none.
      always_comb begin
         dir_s = DIR_NONE;
         case ({up_sync_q[1], dn_sync_q[1]})
            2'b10:   dir_s = DIR_UP;
            2'b01:   dir_s = DIR_DOWN;
            default: dir_s = DIR_NONE;
         endcase
      end

      // Saturating step: a start or reversal always uses the minimum speed.
      always_comb begin
         restart_s  = (state_q == ST_IDLE) || (dir_s != last_dir_q);
         step_s     = restart_s ? SPD_LO : spd_q;
         step_x_s   = (POS_W+1)'(step_s);
         pos_x_s    = {1'b0, pos_q};
         sum_x_s    = pos_x_s + step_x_s;
         diff_s     = pos_q - POS_W'(step_s);
         clamp_s    = 1'b0;
         next_pos_s = pos_q;
         case (dir_s)
            DIR_UP: begin
               if (pos_x_s < (MIN_X + step_x_s)) begin
                  clamp_s    = 1'b1;
                  next_pos_s = MIN_P;
               end else begin
                  clamp_s    = 1'b0;
                  next_pos_s = diff_s;
               end
            end
            DIR_DOWN: begin
               if (sum_x_s > MAX_X) begin
                  clamp_s    = 1'b1;
                  next_pos_s = MAX_P;
               end else begin
                  clamp_s    = 1'b0;
                  next_pos_s = sum_x_s[POS_W-1:0];
               end
            end
            default: begin
               clamp_s    = 1'b0;
               next_pos_s = pos_q;
            end
         endcase
      end

      // Per-channel FSM and speed ramp; everything holds between ticks.
      always_comb begin
         state_d    = state_q;
         spd_d      = spd_q;
         hcnt_d     = hcnt_q;
         last_dir_d = last_dir_q;
         pos_d      = pos_q;
         if (tick) begin
            if (dir_s == DIR_NONE) begin
               state_d = ST_IDLE;
               spd_d   = SPD_LO;
               hcnt_d  = {HC_W{1'b0}};
            end else begin
               state_d    = ST_RUN;
               last_dir_d = dir_s;
               pos_d      = next_pos_s;
               if (clamp_s || restart_s) begin
                  // Hitting a limit or starting fresh drops back to slow.
                  spd_d  = SPD_LO;
                  hcnt_d = {HC_W{1'b0}};
               end else if (hcnt_q == HC_LAST) begin
                  hcnt_d = {HC_W{1'b0}};
                  spd_d  = (spd_q == SPD_HI) ? spd_q : (spd_q + SPD_W'(1));
               end else begin
                  spd_d  = spd_q;
                  hcnt_d = hcnt_q + HC_W'(1);
               end
            end
         end else begin
            state_d    = state_q;
            pos_d      = pos_q;
         end
      end

      // Channel state registers.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            state_q    <= ST_IDLE;
            spd_q      <= SPD_LO;
            hcnt_q     <= {HC_W{1'b0}};
            last_dir_q <= DIR_NONE;
            pos_q      <= INIT_P;
         end else begin
            state_q    <= state_d;
            spd_q      <= spd_d;
            hcnt_q     <= hcnt_d;
            last_dir_q <= last_dir_d;
            pos_q      <= pos_d;
         end
      end

      assign pos[g*POS_W +: POS_W] = pos_q;
      assign at_top[g]             = (pos_q == MIN_P);
      assign at_bot[g]             = (pos_q == MAX_P);
      assign moving[g]             = (state_q == ST_RUN);
   end

endmodule

// File: tb/tb_ctl_paddles.sv
module tb_ctl_paddles;

   localparam int NP    = 2;
   localparam int PW    = 10;
   localparam int PMIN  = 5;
   localparam int PMAX  = 590;
   localparam int PINIT = 63;
   localparam int SMIN  = 1;
   localparam int SMAX  = 4;
   localparam int AF    = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic              tick;
   logic [NP-1:0]     btn_up;
   logic [NP-1:0]     btn_down;
   logic [NP*PW-1:0]  pos;
   logic [NP-1:0]     at_top;
   logic [NP-1:0]     at_bot;
   logic [NP-1:0]     moving;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: position, ticks taken in the current run (0 = idle),
   // last direction, and a two-deep delay line for the button inputs.
   int            m_pos  [NP];
   int            m_k    [NP];
   int            m_last [NP];
   logic [NP-1:0] up_d1, up_d2, dn_d1, dn_d2;

   ctl_paddles #(
      .N_PLY(NP), .POS_W(PW), .POS_MIN(PMIN), .POS_MAX(PMAX), .POS_INIT(PINIT),
      .SPEED_MIN(SMIN), .SPEED_MAX(SMAX), .ACCEL_FRAMES(AF)
   ) dut (
      .clk(clk), .rst(rst), .tick(tick), .btn_up(btn_up), .btn_down(btn_down),
      .pos(pos), .at_top(at_top), .at_bot(at_bot), .moving(moving)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int dut_pos(input int i);
      return int'(pos[i*PW +: PW]);
   endfunction

   // Step size for the k-th tick of a run: first tick slow, then one extra
   // unit of speed every AF ticks, capped.
   function automatic int step_of(input int k);
      int s;
      if (k <= 1) return SMIN;
      s = SMIN + (k - 2) / AF;
      return (s > SMAX) ? SMAX : s;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NP; i++) begin
         m_pos[i]  = PINIT;
         m_k[i]    = 0;
         m_last[i] = 0;
      end
      up_d1 = '0; up_d2 = '0; dn_d1 = '0; dn_d2 = '0;
   endtask

   task automatic model_edge();
      int d, np;
      if (rst) begin
         model_reset();
      end else begin
         if (tick) begin
            for (int i = 0; i < NP; i++) begin
               d = 0;
               if (up_d2[i] && !dn_d2[i]) d = -1;
               else if (dn_d2[i] && !up_d2[i]) d = 1;
               if (d == 0) begin
                  m_k[i] = 0;
               end else begin
                  if (m_k[i] == 0 || d != m_last[i]) m_k[i] = 1;
                  else m_k[i] = m_k[i] + 1;
                  m_last[i] = d;
                  np = m_pos[i] + d * step_of(m_k[i]);
                  if (np < PMIN) begin
                     m_pos[i] = PMIN; m_k[i] = 1;
                  end else if (np > PMAX) begin
                     m_pos[i] = PMAX; m_k[i] = 1;
                  end else begin
                     m_pos[i] = np;
                  end
               end
            end
         end
         up_d2 = up_d1; up_d1 = btn_up;
         dn_d2 = dn_d1; dn_d1 = btn_down;
      end
   endtask

   task automatic compare_all();
      for (int i = 0; i < NP; i++) begin
         chk($sformatf("pos%0d", i),    dut_pos(i), m_pos[i]);
         chk($sformatf("at_top%0d", i), at_top[i],  (m_pos[i] == PMIN) ? 1 : 0);
         chk($sformatf("at_bot%0d", i), at_bot[i],  (m_pos[i] == PMAX) ? 1 : 0);
         chk($sformatf("moving%0d", i), moving[i],  (m_k[i] > 0) ? 1 : 0);
      end
   endtask

   task automatic cyc(input logic tk, input logic [NP-1:0] up, input logic [NP-1:0] dn);
      @(negedge clk);
      tick = tk; btn_up = up; btn_down = dn;
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
   endtask

   // n frames: three quiet clocks then a tick clock, buttons held throughout.
   task automatic hold(input int n, input logic [NP-1:0] up, input logic [NP-1:0] dn);
      for (int f = 0; f < n; f++) begin
         cyc(1'b0, up, dn); cyc(1'b0, up, dn); cyc(1'b0, up, dn);
         cyc(1'b1, up, dn);
      end
   endtask

   initial begin
      int p, p2;
      logic [NP-1:0] ru, rd;
      logic rtk;
      rst = 1'b1; tick = 1'b0; btn_up = '0; btn_down = '0;
      model_reset();
      repeat (3) cyc(1'b0, 2'b00, 2'b00);
      chk("reset_pos0", dut_pos(0), 63);
      chk("reset_moving", moving, 0);
      rst = 1'b0;

      // Idle frames.
      hold(20, 2'b00, 2'b00);
      chk("idle_pos0", dut_pos(0), 63);
      chk("idle_pos1", dut_pos(1), 63);
      chk("idle_moving", moving, 0);
      chk("idle_top", at_top, 0);
      chk("idle_bot", at_bot, 0);

      // Acceleration on channel 0.
      hold(9, 2'b00, 2'b01);
      chk("accel_t9", dut_pos(0), 72);
      hold(8, 2'b00, 2'b01);
      chk("accel_t17", dut_pos(0), 88);
      chk("accel_pos1", dut_pos(1), 63);
      hold(1, 2'b00, 2'b01);
      chk("accel_spd3", dut_pos(0), 91);
      hold(1, 2'b00, 2'b00);
      chk("accel_stop", moving[0], 0);

      // Channel 1 held up into the top limit.
      hold(100, 2'b10, 2'b00);
      chk("top_pos1", dut_pos(1), 5);
      chk("top_flag1", at_top[1], 1);
      chk("top_moving1", moving[1], 1);
      hold(1, 2'b00, 2'b00);
      chk("top_release", moving[1], 0);

      // Both buttons on channel 0, then down held with no ticks.
      p = dut_pos(0);
      hold(10, 2'b01, 2'b01);
      chk("both_pos0", dut_pos(0), p);
      chk("both_moving0", moving[0], 0);
      repeat (1000) cyc(1'b0, 2'b00, 2'b01);
      chk("notick_pos0", dut_pos(0), p);
      hold(1, 2'b00, 2'b00);

      // Reversal: 20 down ticks reach speed 3, first up tick steps by 1.
      p = dut_pos(0);
      hold(20, 2'b00, 2'b01);
      chk("rev_down20", dut_pos(0), p + 34);
      p2 = dut_pos(0);
      hold(1, 2'b01, 2'b00);
      chk("rev_first_up", dut_pos(0), p2 - 1);
      hold(1, 2'b01, 2'b00);
      chk("rev_second_up", dut_pos(0), p2 - 2);

      // One-clock glitch far from any tick.
      hold(1, 2'b00, 2'b00);
      p = dut_pos(0);
      cyc(1'b0, 2'b00, 2'b00);
      cyc(1'b0, 2'b00, 2'b01);
      repeat (6) cyc(1'b0, 2'b00, 2'b00);
      cyc(1'b1, 2'b00, 2'b00);
      chk("glitch_pos0", dut_pos(0), p);

      // Asynchronous reset mid-run, between clock edges.
      hold(12, 2'b00, 2'b01);
      @(negedge clk);
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      chk("arst_pos0", dut_pos(0), 63);
      chk("arst_moving", moving, 0);
      cyc(1'b0, 2'b00, 2'b01);
      cyc(1'b0, 2'b00, 2'b01);
      rst = 1'b0;
      hold(1, 2'b00, 2'b01);
      chk("arst_first_step", dut_pos(0), 64);
      hold(1, 2'b00, 2'b00);

      // Random frames with slowly changing buttons.
      ru = '0; rd = '0;
      for (int c = 0; c < 6000; c++) begin
         for (int i = 0; i < NP; i++) begin
            if ($urandom_range(0, 40) == 0) ru[i] = ~ru[i];
            if ($urandom_range(0, 40) == 0) rd[i] = ~rd[i];
         end
         rtk = ($urandom_range(0, 2) == 0);
         cyc(rtk, ru, rd);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
